pwm_tick_gen: RTL

Pulse-width modulator that consumes the slow divided clock produced by the clock-divider stage as a synchronous tick source, not as a clock. It runs entirely on the 100 MHz system clock, detects rising edges of the divided signal, counts them over a programmable PWM period, and drives a registered PWM output. A new duty value is accepted through a valid/ready handshake and applied only at a period boundary, so the output never glitches mid-period.

---
 rtl/pwm_tick_gen_pkg.sv | 18 +
 rtl/pwm_tick_gen_if.sv | 23 ++
 rtl/pwm_tick_gen_tick_edge_det.sv | 23 ++
 rtl/pwm_tick_gen.sv | 110 +++++++++++
 4 files changed

// File: rtl/pwm_tick_gen_pkg.sv
// pwm_tick_gen shared definitions.
// Defaults and tick-rate planning constants.
package pwm_tick_gen_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_PERIOD = 200;

  localparam int SYS_CLK_HZ       = 100_000_000;
  localparam int TICK_HZ          = 5_000_000;
  localparam int TICKS_PER_PERIOD = DEF_PERIOD;
  localparam int PWM_HZ           = TICK_HZ / TICKS_PER_PERIOD;

  typedef enum logic {
    DUTY_IDLE = 1'b0,
    DUTY_PEND = 1'b1
  } duty_st_t;

endpackage

// File: rtl/pwm_tick_gen_if.sv
// Duty-value valid/ready handshake.
// Source drives duty_in/duty_valid.
interface pwm_tick_gen_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );

endinterface

// File: rtl/pwm_tick_gen_tick_edge_det.sv
// Rising-edge detector for a slow tick level.
// Emits a one-cycle tick per rising edge.
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic tick
);

  logic sig_q;

  // Remember last cycle's level of the tick source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign tick = sig & ~sig_q;

endmodule

// File: rtl/pwm_tick_gen.sv
// Tick-driven PWM generator on the system clock.
// Duty updates land only on period boundaries.
module pwm_tick_gen
  import pwm_tick_gen_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic         clk_100MHz,
  input  logic         rst,
  input  logic         tick_in,
  pwm_tick_gen_if.slave duty,
  output logic         pwm_out,
  output logic         period_start
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] PLEN = WIDTH'(PERIOD);

  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] duty_active;
  logic [WIDTH-1:0] duty_pending;
  logic [WIDTH-1:0] duty_eff;
  logic             pwm_nxt;
  logic             accept;
  logic             apply;
  duty_st_t         st;
  duty_st_t         st_nxt;

  tick_edge_det u_edge (
    .clk  (clk_100MHz),
    .rst  (rst),
    .sig  (tick_in),
    .tick (tick)
  );

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  assign wrap    = tick & (cnt == LAST);

  // Handshake state: a captured duty waits here for the next wrap.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      st <= DUTY_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Accept when idle; apply and reopen on a wrap while pending.
  always_comb begin
    st_nxt = st;
    accept = 1'b0;
    apply  = 1'b0;
    unique case (st)
      DUTY_IDLE: begin
        if (duty.duty_valid) begin
          accept = 1'b1;
          st_nxt = DUTY_PEND;
        end
      end
      DUTY_PEND: begin
        if (wrap) begin
          apply  = 1'b1;
          st_nxt = DUTY_IDLE;
        end
      end
    endcase
  end

  assign duty.duty_ready = (st == DUTY_IDLE);

  assign duty_eff = apply ? duty_pending : duty_active;

  // Compare against the post-edge count and duty, so no extra lag.
  always_comb begin
    pwm_nxt = 1'b0;
    if (duty_eff >= PLEN) begin
      pwm_nxt = 1'b1;
    end else begin
      pwm_nxt = (cnt_nxt < duty_eff);
    end
  end

  // Counter, duty registers and registered outputs.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      duty_active  <= '0;
      duty_pending <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (tick) begin
        cnt     <= cnt_nxt;
        pwm_out <= pwm_nxt;
      end
      if (apply) begin
        duty_active <= duty_pending;
      end
      if (accept) begin
        duty_pending <= duty.duty_in;
      end
    end
  end

endmodule
